// File: rtl/fixed_point_iterative_unit.sv
// fixed_point_iterative_unit: signed Q-format add/sub/mul/div/sqrt.
// Mul, div and sqrt iterate one bit per cycle behind a start/ready handshake.
module fixed_point_iterative_unit #(
    parameter int WIDTH    = 32,
    parameter int FBITS    = 10,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             busy,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             invalid
);
    localparam int DW = WIDTH + FBITS;
    localparam int SN = DW / 2;
    localparam int PW = 2 * WIDTH;
    localparam int XW = 2 * WIDTH + 2;
    localparam int RW = SN + 4;
    localparam int CW = $clog2(DW + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SQRT = 3'b100;

    localparam logic signed [XW-1:0] MAX_X =
        {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_X =
        {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL, DIV, SQRT, FINISH} state_t;

    state_t state, state_d;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, mag_b;
    logic [PW-1:0]    mcand, prod;
    logic [WIDTH-1:0] mplier;
    logic [DW-1:0]    dvd, quo, rad;
    logic [WIDTH-1:0] rem;
    logic [RW-1:0]    srem;
    logic [SN-1:0]    root;
    logic [CW-1:0]    cnt;

    function automatic logic [WIDTH-1:0] magn(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    function automatic logic signed [XW-1:0] sext(input logic [WIDTH-1:0] x);
        return {{(XW-WIDTH){x[WIDTH-1]}}, x};
    endfunction

    // Single-step terms for restoring division and digit-by-digit root
    logic [WIDTH:0]  dtrial;
    logic            dge;
    logic [RW-1:0]   s_sh, s_try;
    logic            sge;

    assign dtrial = {rem, dvd[DW-1]};
    assign dge    = dtrial >= {1'b0, mag_b};
    assign s_sh   = {srem[RW-3:0], rad[DW-1 -: 2]};
    assign s_try  = RW'({root, 2'b01});
    assign sge    = s_sh >= s_try;

    // Sign application, range check and special-case results for FINISH
    logic [XW-1:0]        mag_x;
    logic signed [XW-1:0] sval;
    logic [WIDTH-1:0]     fin_res;
    logic                 fin_ovf, fin_dz, fin_inv;

    always_comb begin
        mag_x   = '0;
        sval    = '0;
        fin_res = '0;
        fin_ovf = 1'b0;
        fin_dz  = 1'b0;
        fin_inv = 1'b0;
        unique case (op_q)
            OP_ADD: sval = sext(a_q) + sext(b_q);
            OP_SUB: sval = sext(a_q) - sext(b_q);
            OP_MUL: begin
                mag_x = XW'(prod >> FBITS);
                sval  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ?
                        -$signed(mag_x) : $signed(mag_x);
            end
            OP_DIV: begin
                mag_x  = XW'(quo);
                sval   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ?
                         -$signed(mag_x) : $signed(mag_x);
                fin_dz = (b_q == '0);
            end
            OP_SQRT: begin
                mag_x   = XW'(root);
                sval    = $signed(mag_x);
                fin_inv = a_q[WIDTH-1];
            end
            default: fin_inv = 1'b1;
        endcase
        if (sval > MAX_X) begin
            fin_ovf = 1'b1;
            fin_res = SATURATE ? MAX_W : sval[WIDTH-1:0];
        end else if (sval < MIN_X) begin
            fin_ovf = 1'b1;
            fin_res = SATURATE ? MIN_W : sval[WIDTH-1:0];
        end else begin
            fin_res = sval[WIDTH-1:0];
        end
        if (fin_dz) begin
            fin_ovf = 1'b0;
            fin_res = a_q[WIDTH-1] ? MIN_W : MAX_W;
        end
        if (fin_inv) begin
            fin_ovf = 1'b0;
            fin_res = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next state: dispatch on opcode, iterate until the counter runs out
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    unique case (operation)
                        OP_MUL:  state_d = MUL;
                        OP_DIV:  state_d = (operand_2 == '0) ? FINISH : DIV;
                        OP_SQRT: state_d = operand_1[WIDTH-1] ? FINISH : SQRT;
                        default: state_d = FINISH;
                    endcase
                end
            end
            MUL, DIV, SQRT: if (cnt == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, iterative datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mag_b       <= '0;
            mcand       <= '0;
            prod        <= '0;
            mplier      <= '0;
            dvd         <= '0;
            quo         <= '0;
            rem         <= '0;
            rad         <= '0;
            srem        <= '0;
            root        <= '0;
            cnt         <= '0;
            result      <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        op_q   <= operation;
                        a_q    <= operand_1;
                        b_q    <= operand_2;
                        mag_b  <= magn(operand_2);
                        mcand  <= PW'(magn(operand_1));
                        mplier <= magn(operand_2);
                        prod   <= '0;
                        dvd    <= {magn(operand_1), {FBITS{1'b0}}};
                        quo    <= '0;
                        rem    <= '0;
                        rad    <= {operand_1, {FBITS{1'b0}}};
                        srem   <= '0;
                        root   <= '0;
                        unique case (operation)
                            OP_MUL:  cnt <= CW'(WIDTH);
                            OP_DIV:  cnt <= CW'(DW);
                            OP_SQRT: cnt <= CW'(SN);
                            default: cnt <= '0;
                        endcase
                    end
                end
                MUL: begin
                    prod   <= prod + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                end
                DIV: begin
                    rem <= dge ? WIDTH'(dtrial - {1'b0, mag_b})
                               : dtrial[WIDTH-1:0];
                    quo <= {quo[DW-2:0], dge};
                    dvd <= dvd << 1;
                    cnt <= cnt - 1'b1;
                end
                SQRT: begin
                    srem <= sge ? (s_sh - s_try) : s_sh;
                    root <= {root[SN-2:0], sge};
                    rad  <= rad << 2;
                    cnt  <= cnt - 1'b1;
                end
                FINISH: begin
                    result      <= fin_res;
                    overflow    <= fin_ovf;
                    div_by_zero <= fin_dz;
                    invalid     <= fin_inv;
                    ready       <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fixed_point_iterative_unit.md
# fixed_point_iterative_unit

Parametrised signed fixed-point arithmetic unit in Q(WIDTH−FBITS).FBITS two's-complement format. It supports add, subtract, multiply, divide and square root. Multiply, divide and square root use bit-serial iterative datapaths. The unit has a start/busy/ready handshake, optional saturation and sticky-free per-result status flags. It sits beside the integer ALU in the execute stage and serves fixed-point instructions issued by the core's control unit.

## Interface
- WIDTH, 32, operand/result width; must be even-sum with FBITS, see below
- FBITS, 10, fractional bits; 0 < FBITS < WIDTH; WIDTH+FBITS must be even
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap (keep low WIDTH bits)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  request; sampled only when in IDLE
- operation  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 SQRT, others invalid
- operand_1  input  WIDTH  first operand / dividend / radicand
- operand_2  input  WIDTH  second operand / divisor; ignored for SQRT
- result  output  WIDTH  registered result; holds until next ready
- ready  output  1  one-cycle pulse: result and flags valid
- busy  output  1  operation in flight
- overflow  output  1  result exceeded representable range (clamped or wrapped)
- div_by_zero  output  1  DIV with operand_2 = 0
- invalid  output  1  SQRT of negative operand or undefined opcode

## Operation
- States: IDLE, MUL, DIV, SQRT, FINISH.
- IDLE with start=1: latch operands, opcode, operand signs and magnitudes.
  - ADD/SUB/invalid go to FINISH.
  - MUL, DIV and SQRT go to their own states with the iteration counter loaded.
- ADD/SUB: full WIDTH+1-bit signed sum. Overflow when the sum falls outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- MUL: shift-add on magnitudes, one multiplier bit per cycle, WIDTH cycles. The 2·WIDTH product is shifted right by FBITS and truncated toward zero. The sign is reapplied in FINISH.
- DIV: restoring division of |op1|·2^FBITS by |op2|, one quotient bit per cycle, WIDTH+FBITS cycles. Truncated toward zero; the sign is the XOR of the operand signs.
  - op2=0: skip iterating and go to FINISH.
  - Result is 2^(WIDTH−1)−1 if op1 ≥ 0, else −2^(WIDTH−1); div_by_zero=1.
- SQRT: digit-by-digit integer root of op1·2^FBITS, (WIDTH+FBITS)/2 cycles, truncated.
  - op1 < 0: go to FINISH with result 0 and invalid=1.
- Invalid opcode: result 0, invalid=1.
- FINISH, on the exiting edge:
  - Apply sign and range check, then saturate or wrap per SATURATE.
  - Register result and flags; ready=1; return to IDLE.
- Flags are not sticky: all three are rewritten at every ready.
- start while busy is ignored; no queueing.

## Timing
- Reset values: result=0, ready=0, busy=0, overflow=0, div_by_zero=0, invalid=0; state IDLE.
- Start accepted at edge E0. busy=1 from E0 until the edge where ready rises; busy=0 while ready=1.
- Latency L (ready high after edge E0+L):
  - ADD/SUB/invalid: L=1
  - MUL: L=WIDTH+1
  - DIV: L=WIDTH+FBITS+1, or L=1 when op2=0
  - SQRT: L=(WIDTH+FBITS)/2+1, or L=1 when op1<0
- ready lasts exactly one cycle.
- start in the ready cycle is accepted (back-to-back issue).
- Operands may change or go X after E0; the unit uses latched copies only.
- Reset asserted mid-operation: the next edge aborts to IDLE with all outputs at reset values; no ready for the aborted request.

## Test plan
All cases use WIDTH=32, FBITS=10, SATURATE=1 unless stated.
- ADD 0x3A00 (14.5) + 0x4100 (16.25) -> result 0x7B00 (30.75) with ready one cycle after the start edge. SUB 0x3A00 − 0x1800 -> 0x2200 (8.5). All flags 0.
- MUL 0x3A00 × 0x1800 -> 0x15C00 (87.0) at L=33. MUL 0xFFFFF600 (−2.5) × 0x1000 (4.0) -> 0xFFFFD800 (−10.0). busy stays high for 33 cycles. A start pulse at cycle 5 is ignored.
- DIV 0x15C00 ÷ 0x1800 -> 0x3A00 at L=43. DIV 0x1400 ÷ 0 -> 0x7FFFFFFF, div_by_zero=1, L=1.
- SQRT 0x900 (2.25) -> 0x600 (1.5) at L=22. SQRT 0xFFFFFC00 -> result 0, invalid=1.
- ADD 0x7FFFFC00 + 0x400 -> 0x7FFFFFFF, overflow=1. Rerun with SATURATE=0 -> 0x80000000, overflow=1. A following ADD clears overflow.
- Start MUL, assert reset for one cycle at iteration 10 -> no ready; all outputs 0 after the reset edge. Then ADD 0x400+0x400 -> 0x800 at L=1.
